// File: rtl/multi_dataflow_job_fsm_pkg.sv
// Shared types and defaults for the multi_dataflow job sequencer.
// The state encoding is visible on state_o, so the enum values are fixed.
package multi_dataflow_job_fsm_pkg;

  localparam int CNT_WIDTH   = 32;
  localparam int STATE_WIDTH = 3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_COMPUTE   = 3'd2,
    ST_UPDATEIDX = 3'd3,
    ST_TERMINATE = 3'd4
  } fsm_state_t;

  // Per-iteration completion flags of the two streamers.
  typedef struct packed {
    logic in_done;
    logic out_done;
  } done_flags_t;

  function automatic logic both_done(input done_flags_t f);
    return f.in_done & f.out_done;
  endfunction

endpackage

// File: rtl/multi_dataflow_job_fsm_if.sv
// Streamer / engine / uloop handshake bundle between the job sequencer
// (master) and the blocks it drives (slave).
interface multi_dataflow_job_fsm_if;

  logic in_req_start_o;
  logic in_ready_i;
  logic in_done_i;
  logic out_req_start_o;
  logic out_ready_i;
  logic out_done_i;
  logic out_beat_i;
  logic engine_start_o;
  logic engine_enable_o;
  logic uloop_enable_o;
  logic uloop_ready_i;
  logic uloop_done_i;

  modport master (
    output in_req_start_o, out_req_start_o, engine_start_o, engine_enable_o, uloop_enable_o,
    input  in_ready_i, in_done_i, out_ready_i, out_done_i, out_beat_i, uloop_ready_i, uloop_done_i
  );

  modport slave (
    input  in_req_start_o, out_req_start_o, engine_start_o, engine_enable_o, uloop_enable_o,
    output in_ready_i, in_done_i, out_ready_i, out_done_i, out_beat_i, uloop_ready_i, uloop_done_i
  );

endinterface

// File: rtl/multi_dataflow_job_fsm_beat_counter.sv
// Saturating outStream0 beat counter with a sticky overrun flag.
// Beats arriving while the count already sits at a non-zero limit raise overrun_o.
module multi_dataflow_beat_counter #(
  parameter int CNT_WIDTH = multi_dataflow_job_fsm_pkg::CNT_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic [CNT_WIDTH-1:0] limit_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic [CNT_WIDTH-1:0] cnt_nxt_o,
  output logic                 at_limit_o,
  output logic                 overrun_o
);

  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_overrun;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic                 w_overrun_nxt;

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    w_cnt_nxt     = r_cnt;
    w_overrun_nxt = r_overrun;
    if (clr_i) begin
      w_cnt_nxt = '0;
    end else if (en_i) begin
      if (r_cnt < limit_i) begin
        w_cnt_nxt = r_cnt + 1'b1;
      end else if (limit_i != '0) begin
        w_overrun_nxt = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt     <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_overrun <= w_overrun_nxt;
    end
  end

  assign cnt_o      = r_cnt;
  assign cnt_nxt_o  = w_cnt_nxt;
  assign at_limit_o = (r_cnt == limit_i);
  assign overrun_o  = r_overrun;

endmodule

// File: rtl/multi_dataflow_job_fsm.sv
// Job sequencer: per uloop iteration start both streams, wait for both dones
// and the outStream0 beat limit, step the uloop, then pulse job done.
module multi_dataflow_job_fsm
  import multi_dataflow_job_fsm_pkg::*;
#(
  parameter int CNT_WIDTH   = multi_dataflow_job_fsm_pkg::CNT_WIDTH,
  parameter int STATE_WIDTH = multi_dataflow_job_fsm_pkg::STATE_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic                   job_start_i,
  input  logic [CNT_WIDTH-1:0]   cnt_limit_i,
  multi_dataflow_job_fsm_if.master bus,
  output logic                   job_done_o,
  output logic                   busy_o,
  output logic                   overrun_o,
  output logic [STATE_WIDTH-1:0] state_o
);

  fsm_state_t  r_state;
  fsm_state_t  w_state_nxt;
  done_flags_t r_flags;
  done_flags_t w_flags_nxt;
  done_flags_t w_flags_live;

  logic                 w_soft_rst;
  logic                 w_accept;
  logic                 w_cnt_en;
  logic                 w_count_met;
  logic                 w_at_limit;
  logic [CNT_WIDTH-1:0] w_beat_cnt;
  logic [CNT_WIDTH-1:0] w_beat_cnt_nxt;

  logic w_in_req;
  logic w_out_req;
  logic w_engine_start;
  logic w_engine_enable;
  logic w_uloop_enable;
  logic w_job_done;
  logic w_busy;

  assign w_soft_rst = rst_i | clear_i;
  assign w_accept   = (r_state == ST_START) & bus.in_ready_i & bus.out_ready_i;
  assign w_cnt_en   = (r_state == ST_COMPUTE) & bus.out_beat_i;

  multi_dataflow_beat_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_beat_counter (
    .clk_i      (clk_i),
    .rst_i      (w_soft_rst),
    .clr_i      (w_accept),
    .en_i       (w_cnt_en),
    .limit_i    (cnt_limit_i),
    .cnt_o      (w_beat_cnt),
    .cnt_nxt_o  (w_beat_cnt_nxt),
    .at_limit_o (w_at_limit),
    .overrun_o  (overrun_o)
  );

  // Exit is judged on next-cycle values so a beat/done in the exit cycle still counts.
  assign w_flags_live.in_done  = r_flags.in_done  | bus.in_done_i;
  assign w_flags_live.out_done = r_flags.out_done | bus.out_done_i;
  assign w_count_met = (cnt_limit_i == '0) | (w_beat_cnt_nxt == cnt_limit_i);

  always_comb begin
    w_state_nxt     = r_state;
    w_flags_nxt     = r_flags;
    w_in_req        = 1'b0;
    w_out_req       = 1'b0;
    w_engine_enable = 1'b0;
    w_uloop_enable  = 1'b0;
    w_job_done      = 1'b0;
    w_busy          = (r_state != ST_IDLE);
    w_engine_start  = w_accept & ~w_soft_rst;

    unique case (r_state)
      ST_IDLE: begin
        if (job_start_i) w_state_nxt = ST_START;
      end
      ST_START: begin
        w_in_req  = 1'b1;
        w_out_req = 1'b1;
        if (w_accept) begin
          w_flags_nxt = '0;
          w_state_nxt = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        w_engine_enable = 1'b1;
        w_flags_nxt     = w_flags_live;
        if (both_done(w_flags_live) && w_count_met) w_state_nxt = ST_UPDATEIDX;
      end
      ST_UPDATEIDX: begin
        w_uloop_enable = 1'b1;
        if (bus.uloop_ready_i) begin
          w_state_nxt = bus.uloop_done_i ? ST_TERMINATE : ST_START;
        end
      end
      ST_TERMINATE: begin
        w_job_done  = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // NOTE: only control state is reset; the counter datapath follows the same soft reset through its own port.
  always_ff @(posedge clk_i) begin
    if (w_soft_rst) begin
      r_state <= ST_IDLE;
      r_flags <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_flags <= w_flags_nxt;
    end
  end

  assign bus.in_req_start_o  = w_in_req;
  assign bus.out_req_start_o = w_out_req;
  assign bus.engine_start_o  = w_engine_start;
  assign bus.engine_enable_o = w_engine_enable;
  assign bus.uloop_enable_o  = w_uloop_enable;
  assign job_done_o          = w_job_done;
  assign busy_o              = w_busy;
  assign state_o             = STATE_WIDTH'(r_state);

  // Within an iteration the count starts at zero and saturates, so it can never pass the limit.
  a_cnt_bounded : assert property (
    @(posedge clk_i) disable iff (w_soft_rst)
      (r_state == ST_COMPUTE && !w_at_limit) |-> (w_beat_cnt < cnt_limit_i)
  );

endmodule

// File: tb/tb_multi_dataflow_job_fsm.sv
// Self-checking bench for multi_dataflow_job_fsm: directed scenarios with literal
// expectations, then random traffic, all compared every cycle to a job-level model.
module tb_multi_dataflow_job_fsm;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        clear_i;
  logic        job_start_i;
  logic [31:0] cnt_limit_i;
  logic        job_done_o;
  logic        busy_o;
  logic        overrun_o;
  logic [2:0]  state_o;

  multi_dataflow_job_fsm_if ifc ();

  multi_dataflow_job_fsm #(.CNT_WIDTH(32), .STATE_WIDTH(3)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .clear_i     (clear_i),
    .job_start_i (job_start_i),
    .cnt_limit_i (cnt_limit_i),
    .bus         (ifc.master),
    .job_done_o  (job_done_o),
    .busy_o      (busy_o),
    .overrun_o   (overrun_o),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_es     = 0;  // engine_start pulses seen
  int n_jd     = 0;  // job_done pulses seen
  int n_upd    = 0;  // entries into the uloop step phase

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- job-level reference model ----------------
  // phase: 0 idle, 1 waiting for stream start, 2 streaming, 3 uloop step, 4 finishing
  int  m_phase = 0;
  bit  m_valid = 0;
  int  m_raw_beats;     // every beat seen this iteration, unbounded
  bit  m_in_seen, m_out_seen, m_ovr;

  always @(posedge clk) begin
    if (rst_i || clear_i) begin
      m_phase = 0; m_raw_beats = 0; m_in_seen = 0; m_out_seen = 0; m_ovr = 0;
      m_valid = 1;
    end else if (m_valid) begin
      case (m_phase)
        0: if (job_start_i) m_phase = 1;
        1: if (ifc.in_ready_i && ifc.out_ready_i) begin
             m_phase = 2; m_raw_beats = 0; m_in_seen = 0; m_out_seen = 0;
           end
        2: begin
             if (ifc.out_beat_i) begin
               if (cnt_limit_i != 0 && m_raw_beats >= int'(cnt_limit_i)) m_ovr = 1;
               m_raw_beats++;
             end
             m_in_seen  = m_in_seen  || ifc.in_done_i;
             m_out_seen = m_out_seen || ifc.out_done_i;
             if (m_in_seen && m_out_seen &&
                 (cnt_limit_i == 0 || m_raw_beats >= int'(cnt_limit_i))) m_phase = 3;
           end
        3: if (ifc.uloop_ready_i) m_phase = ifc.uloop_done_i ? 4 : 1;
        default: m_phase = 0;
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  int prev_state = 0;
  always @(negedge clk) begin
    #2;
    if (m_valid) begin
      check("state_o",         32'(state_o),             32'(m_phase));
      check("busy_o",          32'(busy_o),              32'(m_phase != 0));
      check("in_req_start_o",  32'(ifc.in_req_start_o),  32'(m_phase == 1));
      check("out_req_start_o", 32'(ifc.out_req_start_o), 32'(m_phase == 1));
      check("engine_start_o",  32'(ifc.engine_start_o),
            32'(m_phase == 1 && ifc.in_ready_i && ifc.out_ready_i && !rst_i && !clear_i));
      check("engine_enable_o", 32'(ifc.engine_enable_o), 32'(m_phase == 2));
      check("uloop_enable_o",  32'(ifc.uloop_enable_o),  32'(m_phase == 3));
      check("job_done_o",      32'(job_done_o),          32'(m_phase == 4));
      check("overrun_o",       32'(overrun_o),           32'(m_ovr));
      if (ifc.engine_start_o) n_es++;
      if (job_done_o) n_jd++;
      if (state_o == 3'd3 && prev_state != 3) n_upd++;
      prev_state = int'(state_o);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic zero_inputs();
    job_start_i = 0; clear_i = 0;
    ifc.in_ready_i = 0; ifc.out_ready_i = 0; ifc.in_done_i = 0; ifc.out_done_i = 0;
    ifc.out_beat_i = 0; ifc.uloop_ready_i = 0; ifc.uloop_done_i = 0;
  endtask

  // Apply the current inputs across one rising edge, then return them to idle.
  task automatic cycle();
    @(negedge clk);
    zero_inputs();
  endtask

  task automatic accept();
    ifc.in_ready_i = 1; ifc.out_ready_i = 1; cycle();
  endtask

  task automatic uloop_step(input bit last);
    ifc.uloop_ready_i = 1; ifc.uloop_done_i = last; cycle();
  endtask

  task automatic beats(input int n);
    for (int i = 0; i < n; i++) begin ifc.out_beat_i = 1; cycle(); end
  endtask

  task automatic dones_separate();
    ifc.in_done_i = 1; cycle();
    ifc.out_done_i = 1; cycle();
  endtask

  int es0, jd0, upd0;

  initial begin
    zero_inputs();
    rst_i = 1; cnt_limit_i = 4;
    cycle(); cycle();
    rst_i = 0;
    cycle();
    #1;
    check("reset state", 32'(state_o), 0);
    check("reset busy", 32'(busy_o), 0);
    check("reset overrun", 32'(overrun_o), 0);

    // Nominal: limit 4, two iterations, uloop done on the second step.
    es0 = n_es; jd0 = n_jd; upd0 = n_upd;
    job_start_i = 1; cycle(); #1;
    check("start latency in_req", 32'(ifc.in_req_start_o), 1);
    accept();
    beats(4); dones_separate(); #1;
    check("nominal iter1 updateidx", 32'(state_o), 3);
    uloop_step(0); #1;
    check("nominal back to start", 32'(state_o), 1);
    accept();
    beats(4); dones_separate();
    uloop_step(1); #1;
    check("nominal job_done pulse", 32'(job_done_o), 1);
    cycle(); #1;
    check("nominal busy falls", 32'(busy_o), 0);
    check("nominal engine starts", 32'(n_es - es0), 2);
    check("nominal updateidx entries", 32'(n_upd - upd0), 2);
    check("nominal job_done count", 32'(n_jd - jd0), 1);

    // Split ready, then same-cycle exit (4th beat with both dones).
    es0 = n_es;
    job_start_i = 1; cycle();
    ifc.in_ready_i = 1; cycle();
    ifc.out_ready_i = 1; cycle(); #1;
    check("split ready holds start", 32'(state_o), 1);
    check("split ready no engine start", 32'(n_es - es0), 0);
    accept(); #1;
    check("split ready accepted", 32'(state_o), 2);
    beats(3);
    ifc.out_beat_i = 1; ifc.in_done_i = 1; ifc.out_done_i = 1; cycle(); #1;
    check("same-cycle exit", 32'(state_o), 3);
    check("same-cycle no overrun", 32'(overrun_o), 0);
    uloop_step(1); cycle();

    // Overrun: limit 2, three beats before the dones.
    cnt_limit_i = 2; jd0 = n_jd;
    job_start_i = 1; cycle(); accept();
    beats(2); #1;
    check("overrun not yet", 32'(overrun_o), 0);
    beats(1); #1;
    check("overrun set on 3rd beat", 32'(overrun_o), 1);
    dones_separate(); #1;
    check("overrun exit still works", 32'(state_o), 3);
    uloop_step(1); cycle(); cycle(); #1;
    check("overrun job completes", 32'(n_jd - jd0), 1);
    check("overrun sticky in idle", 32'(overrun_o), 1);

    // Abort with clear_i in COMPUTE.
    cnt_limit_i = 4; jd0 = n_jd;
    job_start_i = 1; cycle(); accept(); beats(1);
    clear_i = 1; cycle(); #1;
    check("abort state idle", 32'(state_o), 0);
    check("abort engine_enable low", 32'(ifc.engine_enable_o), 0);
    check("abort clears overrun", 32'(overrun_o), 0);
    cycle(); #1;
    check("abort no job_done", 32'(n_jd - jd0), 0);

    // Zero limit, job_start ignored mid-job, exit on dones alone.
    cnt_limit_i = 0; jd0 = n_jd;
    job_start_i = 1; cycle(); accept();
    job_start_i = 1; cycle(); #1;
    check("job_start ignored", 32'(state_o), 2);
    ifc.in_done_i = 1; cycle(); #1;
    check("zero limit waits for out_done", 32'(state_o), 2);
    ifc.out_done_i = 1; cycle(); #1;
    check("zero limit exit", 32'(state_o), 3);
    uloop_step(1); cycle(); cycle(); #1;
    check("zero limit job completes", 32'(n_jd - jd0), 1);

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      rst_i   = ($urandom_range(0, 399) == 0);
      clear_i = ($urandom_range(0, 299) == 0);
      if (m_phase == 0 && $urandom_range(0, 2) == 0) cnt_limit_i = $urandom_range(0, 5);
      job_start_i       = ($urandom_range(0, 3) == 0);
      ifc.in_ready_i    = $urandom_range(0, 1);
      ifc.out_ready_i   = $urandom_range(0, 1);
      ifc.out_beat_i    = ($urandom_range(0, 9) < 6);
      ifc.in_done_i     = ($urandom_range(0, 5) == 0);
      ifc.out_done_i    = ($urandom_range(0, 5) == 0);
      ifc.uloop_ready_i = ($urandom_range(0, 2) == 0);
      ifc.uloop_done_i  = $urandom_range(0, 1);
      @(negedge clk);
    end
    rst_i = 0;
    zero_inputs();
    cycle(); cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
